osc_bank_tdm: RTL
=================

// Module: osc_bank_tdm
// PURPOSE
//  Multi-voice, multi-waveform phase-accumulator oscillator bank. Successor to the single-voice sawtooth generator.
//  One shared datapath, time-multiplexed over NUM_VOICES. Each voice has its own increment, waveform mode and pulse width.
//  On each sample tick (step_in) it sweeps all voices and emits one signed sample per voice on a valid/ready stream.
//  Sits between the note/voice allocator (config port) and the voice mixer (sample stream).
// PARAMETERS
//  NUM_VOICES  8   voices per bank; >=2
//  PHASE_W     32  phase accumulator width
//  OUT_W       24  signed sample width; OUT_W <= PHASE_W-1
//  PW_W        16  pulse-width compare width; PW_W <= PHASE_W
// PORTS
//  clk_in        in   1            system clock; sole clock
//  rst_in        in   1            synchronous, active-low reset
//  step_in       in   1            sample tick, 1-cycle pulse; starts a sweep
//  cfg_we        in   1            config write strobe
//  cfg_voice     in   VW           voice index, VW=$clog2(NUM_VOICES)
//  cfg_incr      in   PHASE_W      phase increment
//  cfg_wave      in   2            0=saw up, 1=saw down, 2=square, 3=triangle
//  cfg_pw        in   PW_W         square duty threshold
//  sync_in       in   NUM_VOICES   per-voice hard-sync request, 1-cycle pulse
//  sample_valid  out  1            sample available
//  sample_ready  in   1            mixer accepts sample
//  sample_data   out  OUT_W        signed sample
//  sample_voice  out  VW           voice of sample_data
//  sample_last   out  1            marks voice NUM_VOICES-1 (end of frame)
//  overrun       out  1            sticky; step_in arrived while not IDLE
// BEHAVIOUR
//  Reset (rst_in==0 at posedge) clears all phases, increments, modes, PWs, sync flags, overrun, sample_valid, and the FSM to IDLE.
//  Voice config resets to incr=0, wave=saw up, pw=2^(PW_W-1).
//  FSM states IDLE -> RUN -> IDLE.
//   IDLE: step_in moves to RUN with idx=0.
//   RUN: compute and present sample for idx.
//     sample_valid stays high until sample_valid&&sample_ready; data, voice and last are held stable while stalled.
//     On each handshake, update phase[idx] and increment idx.
//     Handshake at idx==NUM_VOICES-1 returns to IDLE.
//  Timing: first sample_valid appears 1 cycle after step_in (registered output).
//   Zero stall gives 1 sample/cycle; a sweep takes NUM_VOICES cycles.
//  step_in while in RUN is dropped and sets overrun=1. overrun clears only on reset.
//  Phase update: phase[v] <= sync_pend[v] ? 0 : phase[v]+incr[v], mod 2^PHASE_W (wraps silently).
//   The sample uses the pre-update phase.
//  sync_in[v] sets sync_pend[v]; it clears when voice v's phase is updated.
//   If sync_in[v] and the clear coincide, the flag stays set and applies next sweep.
//  Waveforms: p=phase, M=PHASE_W-1, t=p[M -: OUT_W], MAX=2^(OUT_W-1)-1.
//   saw up:   {~t[OUT_W-1], t[OUT_W-2:0]}
//   saw down: bitwise NOT of saw up
//   square:   (p[M -: PW_W] < cfg_pw) ? +MAX : -MAX
//   triangle: f = p[M] ? ~p[M-1 -: OUT_W] : p[M-1 -: OUT_W]; out = {~f[OUT_W-1], f[OUT_W-2:0]}
//  Config writes take effect at the next phase update of that voice. This includes mid-sweep, for voices not yet serviced.
//   A write never alters phase.
//   If cfg_voice >= NUM_VOICES, the write is ignored.
//  Reset mid-sweep aborts the sweep immediately. No partial frame is completed.
// STRUCTURE
//  Package osc_pkg: wave_e enum (SAW_UP, SAW_DN, SQUARE, TRI) and fsm_e (IDLE, RUN).
//  Sub-module osc_wave_shaper: combinational phase, wave, pw -> sample.
//   Parametrised PHASE_W, OUT_W, PW_W; reusable by the LFO block.
//  Per-voice state is held in register arrays, not RAM, so a same-cycle config write is visible.
// TESTING (NUM_VOICES=4, PHASE_W=32, OUT_W=8, PW_W=16)
//  1. Reset, v0 incr=0x0100_0000 saw up, four steps with ready=1 -> v0 samples -128,-127,-126,-125; sample_last on v3 only.
//  2. v1 square pw=0x8000, incr=0x4000_0000 -> +127,+127,-127,-127, repeating.
//  3. v2 triangle, incr=0x4000_0000 -> -128,0,127,-1, repeating; v2 saw down at phase 0 -> 127.
//  4. Hold sample_ready=0 for 5 cycles mid-sweep -> data/voice stable, no phase advance; step_in during stall sets overrun.
//  5. sync_in[0] between sweeps with v0 at phase 0x0300_0000 -> sample -125 then -128; wrap 0xFF00_0000+0x0100_0000 -> 0.
//  6. rst_in low mid-sweep -> sample_valid=0 next cycle, IDLE, all phases 0, overrun 0.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types for the time-multiplexed oscillator bank.
// Waveform modes and sweep FSM states.
package osc_pkg;

  typedef enum logic [1:0] {
    SAW_UP = 2'd0,
    SAW_DN = 2'd1,
    SQUARE = 2'd2,
    TRI    = 2'd3
  } wave_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/osc_wave_shaper.sv
// Combinational phase -> signed sample shaper.
// Shared by the oscillator bank and the LFO block.
module osc_wave_shaper
  import osc_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 24,
  parameter int PW_W    = 16
) (
  input  logic [PHASE_W-1:0] phase,
  input  wave_e              wave,
  input  logic [PW_W-1:0]    pw,
  output logic [OUT_W-1:0]   sample
);

  localparam int M = PHASE_W - 1;

  localparam logic [OUT_W-1:0] POS_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX =
    {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  logic [OUT_W-1:0] t;
  logic [OUT_W-1:0] f;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] tri_w;
  logic [OUT_W-1:0] sq;

  assign t = phase[M -: OUT_W];
  // Fold the upper half back down to get a symmetric ramp.
  assign f = phase[M] ? ~phase[M-1 -: OUT_W]
                      :  phase[M-1 -: OUT_W];

  assign saw   = {~t[OUT_W-1], t[OUT_W-2:0]};
  assign tri_w = {~f[OUT_W-1], f[OUT_W-2:0]};
  assign sq    = (phase[M -: PW_W] < pw) ? POS_MAX
                                         : NEG_MAX;

  always_comb begin
    sample = saw;
    unique case (1'b1)
      wave == SAW_UP: sample = saw;
      wave == SAW_DN: sample = ~saw;
      wave == SQUARE: sample = sq;
      wave == TRI:    sample = tri_w;
    endcase
  end

endmodule

// File: rtl/osc_bank_tdm.sv
// Multi-voice phase-accumulator oscillator bank.
// One shaper is swept over all voices per sample tick.
module osc_bank_tdm
  import osc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 24,
  parameter int PW_W       = 16,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  step_in,
  input  logic                  cfg_we,
  input  logic [VW-1:0]         cfg_voice,
  input  logic [PHASE_W-1:0]    cfg_incr,
  input  logic [1:0]            cfg_wave,
  input  logic [PW_W-1:0]       cfg_pw,
  input  logic [NUM_VOICES-1:0] sync_in,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [OUT_W-1:0]      sample_data,
  output logic [VW-1:0]         sample_voice,
  output logic                  sample_last,
  output logic                  overrun
);

  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic [PW_W-1:0] PW_RST =
    {1'b1, {(PW_W-1){1'b0}}};

  fsm_e state_q, state_d;

  logic [PHASE_W-1:0]    phase  [NUM_VOICES];
  logic [PHASE_W-1:0]    incr_q [NUM_VOICES];
  wave_e                 wave_q [NUM_VOICES];
  logic [PW_W-1:0]       pw_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] sync_pend;
  logic [NUM_VOICES-1:0] sync_clr;
  logic [VW-1:0]         idx;

  logic               cfg_ok;
  logic               fire;
  logic [VW-1:0]      nidx;
  logic [VW-1:0]      sel;
  logic [PHASE_W-1:0] incr_eff;
  wave_e              wave_s;
  logic [PW_W-1:0]    pw_s;
  logic [OUT_W-1:0]   shaped;

  assign cfg_ok = cfg_we &&
    ({1'b0, cfg_voice} < (VW+1)'(NUM_VOICES));
  assign fire = (state_q == RUN) && sample_valid &&
                sample_ready;
  assign nidx = (idx == LAST) ? '0 : idx + 1'b1;
  assign sel  = (state_q == IDLE) ? '0 : nidx;

  // Bypass same-cycle config writes into the datapath.
  assign incr_eff = (cfg_ok && cfg_voice == idx) ?
                    cfg_incr : incr_q[idx];
  assign wave_s = (cfg_ok && cfg_voice == sel) ?
                  wave_e'(cfg_wave) : wave_q[sel];
  assign pw_s   = (cfg_ok && cfg_voice == sel) ?
                  cfg_pw : pw_q[sel];

  always_comb begin
    sync_clr = '0;
    if (fire) sync_clr[idx] = 1'b1;
  end

  osc_wave_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W),
    .PW_W    (PW_W)
  ) u_shaper (
    .phase  (phase[sel]),
    .wave   (wave_s),
    .pw     (pw_s),
    .sample (shaped)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (step_in) state_d = RUN;
      RUN:  if (fire && idx == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v]  <= '0;
        incr_q[v] <= '0;
        wave_q[v] <= SAW_UP;
        pw_q[v]   <= PW_RST;
      end
      sync_pend    <= '0;
      idx          <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (cfg_ok) begin
        incr_q[cfg_voice] <= cfg_incr;
        wave_q[cfg_voice] <= wave_e'(cfg_wave);
        pw_q[cfg_voice]   <= cfg_pw;
      end
      // A new request wins over a same-cycle clear.
      sync_pend <= sync_in | (sync_pend & ~sync_clr);
      if (state_q == RUN && step_in) overrun <= 1'b1;
      if (state_q == IDLE && step_in) begin
        idx          <= '0;
        sample_valid <= 1'b1;
        sample_data  <= shaped;
      end
      if (fire) begin
        phase[idx] <= sync_pend[idx] ? '0
                                     : phase[idx] + incr_eff;
        if (idx == LAST) begin
          sample_valid <= 1'b0;
        end else begin
          idx         <= nidx;
          sample_data <= shaped;
        end
      end
    end
  end

  assign sample_voice = idx;
  assign sample_last  = (idx == LAST);

endmodule
